// File: rtl/ser_pkg.sv
// Shared types and constants for the ser_* serializer pipeline stages.
package ser_pkg;

  localparam int unsigned DRAM_LANES      = 8;
  localparam int unsigned SER_ENTRY_BYTES = 16;
  localparam logic [7:0]  SER_TYPE_MSG    = 8'h01;

  // One field-table entry: descriptor word on top, sub-table pointer below.
  typedef struct packed {
    logic [63:0] desc;
    logic [63:0] ptr;
  } table_entry_t;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_RD_DESC,
    FS_RD_PTR,
    FS_ISSUE,
    FS_WAIT_DONE,
    FS_FINISH
  } fetch_state_t;

endpackage

// File: rtl/ser_table_fetch_if.sv
// Aggregator handshake and 8-lane byte DRAM port of the table fetcher.
interface ser_table_fetch_if;

  logic                                                     agg_en;
  logic                                                     agg_entry_valid;
  ser_pkg::table_entry_t                                    agg_entry;
  logic [63:0]                                              agg_addr;
  logic                                                     agg_ready;
  logic                                                     agg_done;
  logic [ser_pkg::DRAM_LANES-1:0]                           dram_en;
  logic                                                     dram_rdwr;
  logic [ser_pkg::DRAM_LANES-1:0][63:0]                     dram_addr;
  logic [ser_pkg::DRAM_LANES-1:0][7:0]                      dram_data_in;
  logic [ser_pkg::DRAM_LANES-1:0]                           dram_valid;

  // Fetcher side.
  modport master (
    output agg_en, agg_entry_valid, agg_entry, agg_addr,
    input  agg_ready, agg_done,
    output dram_en, dram_rdwr, dram_addr,
    input  dram_data_in, dram_valid
  );

  // Aggregator / DRAM side.
  modport slave (
    input  agg_en, agg_entry_valid, agg_entry, agg_addr,
    output agg_ready, agg_done,
    input  dram_en, dram_rdwr, dram_addr,
    output dram_data_in, dram_valid
  );

endinterface

// File: rtl/dram_word_reader.sv
// Reads one little-endian 64-bit word over the 8-lane byte DRAM port.
// Lanes may return in different cycles; enables and addresses are held
// until every lane has delivered, then dropped with a word_done pulse.
module dram_word_reader
  import ser_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  input  logic [63:0]                  base,
  output logic [DRAM_LANES-1:0]        dram_en,
  output logic [DRAM_LANES-1:0][63:0]  dram_addr,
  input  logic [DRAM_LANES-1:0][7:0]   dram_data_in,
  input  logic [DRAM_LANES-1:0]        dram_valid,
  output logic [63:0]                  word,
  output logic                         word_done
);

  logic [DRAM_LANES-1:0] seen;
  logic [DRAM_LANES-1:0] hit_c;

  // Lanes delivering data this cycle for the first time.
  assign hit_c = dram_en & dram_valid & ~seen;

  // Issue, per-lane capture and completion of one word read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dram_en   <= '0;
      dram_addr <= '0;
      seen      <= '0;
      word      <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (go) begin
        dram_en <= '1;
        seen    <= '0;
        for (int unsigned i = 0; i < DRAM_LANES; i++) begin
          dram_addr[i] <= base + 64'(i);
        end
      end else if (dram_en != '0) begin
        for (int unsigned i = 0; i < DRAM_LANES; i++) begin
          if (hit_c[i]) word[8*i +: 8] <= dram_data_in[i];
        end
        seen <= seen | hit_c;
        if ((seen | hit_c) == '1) begin
          dram_en   <= '0;
          word_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ser_table_fetch.sv
// Walks a message field table in DRAM, feeding each entry to ser_aggregate
// and descending into nested sub-tables through a return-address stack.
module ser_table_fetch
  import ser_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned ENTRY_BYTES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [63:0]       table_base,
  input  logic [63:0]       obj_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  ser_table_fetch_if.master bus
);

  localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [63:0] STRIDE = 64'(ENTRY_BYTES);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  // The table stride is fixed by the entry format; reject any other value.
  if (ENTRY_BYTES != SER_ENTRY_BYTES) begin : g_entry_bytes_check
    $error("ser_table_fetch: ENTRY_BYTES must equal SER_ENTRY_BYTES");
  end
  if (STACK_DEPTH < 1) begin : g_stack_depth_check
    $error("ser_table_fetch: STACK_DEPTH must be at least 1");
  end

  fetch_state_t   state;
  logic [63:0]    cur;
  logic [63:0]    desc;
  logic [63:0]    ptr;
  logic [63:0]    stack [STACK_DEPTH];
  logic [SP_W-1:0] sp;

  logic           rd_go;
  logic [63:0]    rd_base;
  logic [63:0]    rd_word;
  logic           rd_done;

  logic           agg_en_q;
  logic           agg_valid_q;
  table_entry_t   agg_entry_q;
  logic [63:0]    agg_addr_q;

  dram_word_reader u_reader (
    .clk          (clk),
    .reset        (reset),
    .go           (rd_go),
    .base         (rd_base),
    .dram_en      (bus.dram_en),
    .dram_addr    (bus.dram_addr),
    .dram_data_in (bus.dram_data_in),
    .dram_valid   (bus.dram_valid),
    .word         (rd_word),
    .word_done    (rd_done)
  );

  assign bus.dram_rdwr       = 1'b0;
  assign bus.agg_en          = agg_en_q;
  assign bus.agg_entry_valid = agg_valid_q;
  assign bus.agg_entry       = agg_entry_q;
  assign bus.agg_addr        = agg_addr_q;

  // Table-walk FSM with return stack and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FS_IDLE;
      cur         <= '0;
      desc        <= '0;
      ptr         <= '0;
      sp          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rd_go       <= 1'b0;
      rd_base     <= '0;
      agg_en_q    <= 1'b0;
      agg_valid_q <= 1'b0;
      agg_entry_q <= '0;
      agg_addr_q  <= '0;
    end else begin
      rd_go <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        FS_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            err        <= 1'b0;
            sp         <= '0;
            agg_addr_q <= obj_addr;
            cur        <= table_base;
            rd_base    <= table_base;
            rd_go      <= 1'b1;
            state      <= FS_RD_DESC;
          end
        end
        FS_RD_DESC: begin
          if (rd_done) begin
            desc    <= rd_word;
            rd_base <= cur + 64'd8;
            rd_go   <= 1'b1;
            state   <= FS_RD_PTR;
          end
        end
        FS_RD_PTR: begin
          if (rd_done) begin
            ptr         <= rd_word;
            agg_entry_q <= '{desc: desc, ptr: rd_word};
            state       <= FS_ISSUE;
          end
        end
        FS_ISSUE: begin
          if (bus.agg_ready) begin
            agg_en_q    <= 1'b1;
            agg_valid_q <= 1'b1;
            state       <= FS_WAIT_DONE;
          end
        end
        FS_WAIT_DONE: begin
          if (bus.agg_done) begin
            agg_en_q    <= 1'b0;
            agg_valid_q <= 1'b0;
            if (desc == '0) begin
              if (sp == '0) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FS_FINISH;
              end else begin
                cur     <= stack[IDX_W'(sp - SP_W'(1))];
                rd_base <= stack[IDX_W'(sp - SP_W'(1))];
                sp      <= sp - SP_W'(1);
                rd_go   <= 1'b1;
                state   <= FS_RD_DESC;
              end
            end else if (desc[7:0] == SER_TYPE_MSG) begin
              if (sp == SP_FULL) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FS_FINISH;
              end else begin
                stack[IDX_W'(sp)] <= cur + STRIDE;
                sp      <= sp + SP_W'(1);
                cur     <= ptr;
                rd_base <= ptr;
                rd_go   <= 1'b1;
                state   <= FS_RD_DESC;
              end
            end else begin
              cur     <= cur + STRIDE;
              rd_base <= cur + STRIDE;
              rd_go   <= 1'b1;
              state   <= FS_RD_DESC;
            end
          end
        end
        FS_FINISH: begin
          state <= FS_IDLE;
        end
        default: begin
          state <= FS_IDLE;
        end
      endcase
    end
  end

endmodule
